fifo_wr_arb: RTL and testbench

//  Round-robin write-port arbiter that shares one 8-deep FIFO write interface among N producers.
//  - Each producer uses a valid/ready handshake.
//  - The arbiter grants one producer at a time and holds that grant for a burst of up to BURST beats.
//  - It drives the FIFO's in/we, and honours full as backpressure.
//  - Sits between producer blocks and the fifo instance in the top-level datapath.

---
 rtl/fifo_wr_arb_pkg.sv | 49 ++++
 rtl/fifo_wr_arb_rr_pick.sv | 26 ++
 rtl/fifo_wr_arb.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types, constants and the round-robin search helper
//                used by the FIFO write-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Width of each per-requester accepted-beat counter.
    localparam int STAT_W = 16;

    // Upper bounds on requester count; the helper works at this fixed width
    // and callers zero-extend / truncate around it.
    localparam int MAX_N  = 8;
    localparam int MAX_IW = 3;

    // Return the first set bit of req searching ptr+1, ptr+2, ... mod n.
    // When nothing is set the pointer itself is returned; callers qualify
    // the result with an any-request flag.
    function automatic logic [MAX_IW-1:0] rr_next(
        input logic [MAX_N-1:0]  req,
        input logic [MAX_IW-1:0] ptr,
        input int unsigned       n
    );
        logic [MAX_IW-1:0] pick;
        logic [MAX_IW-1:0] k;
        logic              found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_N; i++) begin
            if (!found && (i <= n)) begin
                k = MAX_IW'((32'(ptr) + i) % n);
                if (req[k]) begin
                    pick  = k;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Reports whether any
//                request is pending and the index of the first requester
//                after ptr (wrapping), so the last winner has lowest priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    assign any = |req;
    assign idx = IW'(rr_next(MAX_N'(req), MAX_IW'(ptr), N));

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arb
//  Description : Round-robin arbiter sharing one FIFO write port among N
//                valid/ready producers. A grant is held for up to BURST
//                accepted beats, or until the granted producer drops valid,
//                after which one arbitration cycle picks the next producer.
//                fifo_full stalls the burst without losing the grant.
//                Optional macro ARB_STATS_EN adds saturating 16-bit
//                per-requester accepted-beat counters on stat_cnt; without
//                it stat_cnt is constant zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic [W-1:0]         fifo_in,
    output logic                 fifo_we,
    input  logic                 fifo_full,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic [N*STAT_W-1:0]  stat_cnt
);

    localparam int            IW        = $clog2(N);
    localparam int            BW        = $clog2(BURST) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
    localparam logic [IW-1:0] PTR_RESET = IW'(N - 1);

    arb_state_t    state_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] grant_q;
    logic [BW-1:0] beat_cnt_q;

    logic          w_any;
    logic [IW-1:0] w_pick;
    logic          w_lock;
    logic          w_valid_g;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (w_any),
        .idx (w_pick)
    );

    assign w_lock    = (state_q == LOCK);
    assign w_valid_g = req_valid[grant_q];
    assign busy      = w_lock;
    assign grant_id  = grant_q;

    // Steer the granted producer onto the FIFO port; everything is quiet outside LOCK.
    always_comb begin
        req_ready = '0;
        fifo_in   = '0;
        fifo_we   = 1'b0;
        if (w_lock) begin
            req_ready[grant_q] = ~fifo_full;
            fifo_in            = req_data[32'(grant_q)*W +: W];
            fifo_we            = w_valid_g & ~fifo_full;
        end
    end

    // Arbitration FSM: pick in IDLE, then hold the grant until the burst ends or valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_RESET;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_any) begin
                        grant_q    <= w_pick;
                        beat_cnt_q <= '0;
                        state_q    <= LOCK;
                    end
                end
                LOCK: begin
                    if (!w_valid_g) begin
                        // Producer went away: release without writing.
                        state_q <= IDLE;
                        ptr_q   <= grant_q;
                    end else if (!fifo_full) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q <= IDLE;
                            ptr_q   <= grant_q;
                        end
                        beat_cnt_q <= beat_cnt_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_stat
            logic [STAT_W-1:0] stat_q;

            // Count accepted beats for this requester, holding at the ceiling.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stat_q <= '0;
                end else if (fifo_we && (grant_q == IW'(gi)) &&
                             (stat_q != {STAT_W{1'b1}})) begin
                    stat_q <= stat_q + STAT_W'(1);
                end
            end

            assign stat_cnt[gi*STAT_W +: STAT_W] = stat_q;
        end
    endgenerate
`else
    assign stat_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arb
//  Description : Self-checking bench for fifo_wr_arb. Directed producer
//                scenarios push hand-derived (grant, data) expectations into
//                a scoreboard; an independent monitor pops and compares on
//                every FIFO write. Stats are checked when ARB_STATS_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int BURST = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   fifo_in;
    logic           fifo_we;
    logic           fifo_full;
    logic [1:0]     grant_id;
    logic           busy;
    logic [N*16-1:0] stat_cnt;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .N     (N),
        .W     (W),
        .BURST (BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_in   (fifo_in),
        .fifo_we   (fifo_we),
        .fifo_full (fifo_full),
        .grant_id  (grant_id),
        .busy      (busy),
        .stat_cnt  (stat_cnt)
    );

    typedef struct {
        logic [1:0] gid;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Producer model: requester i offers base[i]+idx[i] while idx[i] < cnt[i].
    logic [N-1:0] en;
    int           cnt  [N];
    int           idx  [N];
    logic [7:0]   base [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [7:0] d);
        exp_t e;
        e.gid  = g;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = en[i] && (idx[i] < cnt[i]);
            req_data[i*W +: W] = base[i] + 8'(idx[i]);
        end
    endtask

    // One clock: capture handshakes at negedge, advance producers after the edge.
    task automatic cyc();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) idx[i]++;
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        en        = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) idx[i] = 0;
        drive();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic chk_stats(input string name, input logic [63:0] hand);
`ifdef ARB_STATS_EN
        chk(name, 64'(stat_cnt), hand);
`else
        chk(name, 64'(stat_cnt), 64'd0);
`endif
    endtask

    // Scoreboard monitor: every FIFO write must match the next expected beat.
    always @(negedge clk) begin
        if (fifo_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got data=0x%0h grant=%0d expected no write at t=%0t",
                         fifo_in, grant_id, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_data", 64'(fifo_in), 64'(e.data));
                chk("wr_grant", 64'(grant_id), 64'(e.gid));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        en        = '0;
        for (int i = 0; i < N; i++) begin
            cnt[i]  = 0;
            idx[i]  = 0;
            base[i] = 8'h00;
        end

        // Reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_we",    64'(fifo_we),   64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_in",    64'(fifo_in),   64'd0);
        chk("rst_gid",   64'(grant_id),  64'd0);
        chk("rst_stat",  64'(stat_cnt),  64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // A: single requester, 6 beats -> idle, 4 beats, idle, 2 beats
        for (int k = 0; k < 6; k++) push(2'd0, 8'h10 + 8'(k));
        en[0] = 1'b1; cnt[0] = 6; base[0] = 8'h10;
        drive();
        #1;
        chk("A_idle_busy", 64'(busy),    64'd0);
        chk("A_idle_we",   64'(fifo_we), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("A_burst1_we", 64'(fifo_we), 64'd1);
        end
        cyc();
        chk("A_gap_busy", 64'(busy),    64'd0);
        chk("A_gap_we",   64'(fifo_we), 64'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("A_burst2_we", 64'(fifo_we), 64'd1);
        end
        repeat (3) cyc();
        chk("A_drain", 64'(sb.size()), 64'd0);
        chk_stats("A_stats", {16'd0, 16'd0, 16'd0, 16'd6});

        // B: all four valid, 8 beats each -> grants 0,1,2,3,0,1,2,3 of 4 beats
        do_reset();
        base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0; base[3] = 8'hD0;
        for (int r = 0; r < 2; r++)
            for (int g = 0; g < N; g++)
                for (int k = 0; k < BURST; k++)
                    push(2'(g), base[g] + 8'(r*BURST + k));
        for (int i = 0; i < N; i++) begin
            en[i]  = 1'b1;
            cnt[i] = 8;
        end
        drive();
        #1;
        repeat (44) cyc();
        chk("B_drain", 64'(sb.size()), 64'd0);
        chk_stats("B_stats", {16'd8, 16'd8, 16'd8, 16'd8});

        // C: fifo_full for 3 cycles after two beats
        do_reset();
        for (int k = 0; k < 4; k++) push(2'd0, 8'h30 + 8'(k));
        en[0] = 1'b1; cnt[0] = 4; base[0] = 8'h30;
        drive();
        #1;
        repeat (3) cyc();
        fifo_full = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc();
            chk("C_full_we",    64'(fifo_we),   64'd0);
            chk("C_full_ready", 64'(req_ready), 64'd0);
            chk("C_full_gid",   64'(grant_id),  64'd0);
            chk("C_full_busy",  64'(busy),      64'd1);
        end
        cyc();
        fifo_full = 1'b0;
        #1;
        chk("C_resume_we", 64'(fifo_we), 64'd1);
        repeat (4) cyc();
        chk("C_drain", 64'(sb.size()), 64'd0);
        chk_stats("C_stats", {16'd0, 16'd0, 16'd0, 16'd4});

        // D: requester 1 drops valid after 2 beats; 2 must beat 0 next
        do_reset();
        push(2'd1, 8'h50); push(2'd1, 8'h51); push(2'd2, 8'h60); push(2'd0, 8'h40);
        en[1] = 1'b1; cnt[1] = 2; base[1] = 8'h50;
        drive();
        #1;
        cyc();
        en[0] = 1'b1; cnt[0] = 1; base[0] = 8'h40;
        en[2] = 1'b1; cnt[2] = 1; base[2] = 8'h60;
        drive();
        #1;
        chk("D_lock_gid", 64'(grant_id), 64'd1);
        cyc();
        cyc();
        chk("D_drop_busy", 64'(busy),     64'd1);
        chk("D_drop_we",   64'(fifo_we),  64'd0);
        chk("D_drop_gid",  64'(grant_id), 64'd1);
        cyc();
        chk("D_idle_busy", 64'(busy), 64'd0);
        cyc();
        chk("D_next_gid", 64'(grant_id), 64'd2);
        repeat (6) cyc();
        chk("D_drain", 64'(sb.size()), 64'd0);
        chk_stats("D_stats", {16'd0, 16'd1, 16'd2, 16'd1});

        // E: asynchronous reset during beat 2 of 4, then restart from requester 0
        do_reset();
        push(2'd0, 8'h70);
        en[0] = 1'b1; cnt[0] = 4; base[0] = 8'h70;
        en[1] = 1'b1; cnt[1] = 4; base[1] = 8'h80;
        drive();
        #1;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("E_rst_busy",  64'(busy),      64'd0);
        chk("E_rst_we",    64'(fifo_we),   64'd0);
        chk("E_rst_ready", 64'(req_ready), 64'd0);
        chk("E_rst_in",    64'(fifo_in),   64'd0);
        chk("E_rst_gid",   64'(grant_id),  64'd0);
        for (int k = 1; k < 4; k++) push(2'd0, 8'h70 + 8'(k));
        for (int k = 0; k < 4; k++) push(2'd1, 8'h80 + 8'(k));
        cyc();
        rst = 1'b0;
        #1;
        cyc();
        chk("E_restart_busy", 64'(busy),     64'd1);
        chk("E_restart_gid",  64'(grant_id), 64'd0);
        repeat (14) cyc();
        chk("E_drain", 64'(sb.size()), 64'd0);
        chk_stats("E_stats", {16'd0, 16'd0, 16'd4, 16'd3});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
